qspi_sram_responder: RTL and testbench

QSPI_SRAM_RESPONDER -- requirements
Module: qspi_sram_responder

---
 rtl/qspi_sram_responder_pkg.sv | 29 ++
 rtl/qspi_sram_responder_mem.sv | 27 ++
 rtl/qspi_sram_responder.sv | 216 +++++++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder_pkg
// Brief    : Shared command codes, phase lengths and FSM states for the
//            QSPI SRAM responder.
// Revision : 1.0
// ============================================================================
package qspi_sram_responder_pkg;

    localparam logic [7:0] CMD_EQIO  = 8'h38;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RSTIO = 8'hFF;

    localparam int ADDR_NIBBLES  = 6;
    localparam int DUMMY_NIBBLES = 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD        = 3'd1,
        ADDR       = 3'd2,
        DUMMY      = 3'd3,
        WRITE_DATA = 3'd4,
        READ_DATA  = 3'd5,
        IGNORE     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_sram_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder_mem
// Brief    : Single-port synchronous byte RAM, 1-clk read latency, no reset.
// Revision : 1.0
// ============================================================================
module qspi_sram_responder_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/qspi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder
// Brief    : SPI/SQI serial SRAM slave model running in the system clk domain.
// Revision : 1.0
// ============================================================================
module qspi_sram_responder
    import qspi_sram_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sram_cs_n,
    input  logic       sram_sck,
    input  logic [3:0] sram_sio_i,
    output logic [3:0] sram_sio_o,
    output logic       sram_sio_oe,
    output logic       quad_mode,
    output logic       selected
);

    localparam logic [2:0] c_addr_last  = 3'(ADDR_NIBBLES - 1);
    localparam logic [2:0] c_dummy_last = 3'(DUMMY_NIBBLES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_addr_one = MEM_ADDR_WIDTH'(1);

    state_t                    r_state, w_state;
    logic                      r_sck_prev, r_cs_n_prev, r_selected;
    logic [2:0]                r_count, w_count;
    logic [7:0]                r_shift, w_shift;
    logic [MEM_ADDR_WIDTH-1:0] r_addr, w_addr, w_addr_shifted;
    logic                      r_is_read, w_is_read;
    logic                      r_cmd_done, w_cmd_done;
    logic [7:0]                r_rd_byte, w_rd_byte;
    logic [3:0]                r_sio_o, w_sio_o;
    logic                      r_oe, w_oe;
    logic                      r_quad, w_quad;

    logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic [7:0] w_cmd_byte, w_data_byte;
    logic [2:0] w_cmd_last;
    logic       w_mem_we;
    logic [7:0] w_mem_rdata;

    assign w_sck_rise  = sram_sck & ~r_sck_prev;
    assign w_sck_fall  = ~sram_sck & r_sck_prev;
    // Previous CS is forced "low" by reset so a CS already held low is not a fresh fall.
    assign w_cs_rise   = sram_cs_n & ~r_cs_n_prev;
    assign w_cs_fall   = ~sram_cs_n & r_cs_n_prev;
    assign w_data_byte = {r_shift[3:0], sram_sio_i};
    assign w_cmd_byte  = r_quad ? w_data_byte : {r_shift[6:0], sram_sio_i[0]};
    assign w_cmd_last  = r_quad ? 3'd1 : 3'd7;

    generate
        if (MEM_ADDR_WIDTH > 4) begin : g_addr_wide
            assign w_addr_shifted = {r_addr[MEM_ADDR_WIDTH-5:0], sram_sio_i};
        end else begin : g_addr_narrow
            assign w_addr_shifted = sram_sio_i[MEM_ADDR_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_shift    = r_shift;
        w_addr     = r_addr;
        w_is_read  = r_is_read;
        w_cmd_done = r_cmd_done;
        w_rd_byte  = r_rd_byte;
        w_sio_o    = r_sio_o;
        w_oe       = r_oe;
        w_quad     = r_quad;
        w_mem_we   = 1'b0;

        if (w_cs_rise) begin
            w_state = IDLE;
            w_oe    = 1'b0;
            if (r_state == CMD && r_cmd_done) begin
                if (!r_quad && r_shift == CMD_EQIO) begin
                    w_quad = 1'b1;
                end else if (r_quad && r_shift == CMD_RSTIO) begin
                    w_quad = 1'b0;
                end
            end
        end else if (w_cs_fall) begin
            w_state    = CMD;
            w_count    = 3'd0;
            w_shift    = 8'd0;
            w_cmd_done = 1'b0;
            w_oe       = 1'b0;
        end else begin
            case (r_state)
                CMD: begin
                    if (w_sck_rise && !r_cmd_done) begin
                        w_shift = w_cmd_byte;
                        w_count = r_count + 3'd1;
                        if (r_count == w_cmd_last) begin
                            w_count = 3'd0;
                            // Mode-change commands complete here and take effect at CS rise.
                            if (!r_quad) begin
                                if (w_cmd_byte == CMD_EQIO) w_cmd_done = 1'b1;
                                else                        w_state    = IGNORE;
                            end else begin
                                case (w_cmd_byte)
                                    CMD_WRITE: begin w_state = ADDR; w_is_read = 1'b0; end
                                    CMD_READ:  begin w_state = ADDR; w_is_read = 1'b1; end
                                    CMD_RSTIO: w_cmd_done = 1'b1;
                                    default:   w_state = IGNORE;
                                endcase
                            end
                        end
                    end
                end
                ADDR: begin
                    if (w_sck_rise) begin
                        w_addr  = w_addr_shifted;
                        w_count = r_count + 3'd1;
                        if (r_count == c_addr_last) begin
                            w_count = 3'd0;
                            w_state = r_is_read ? DUMMY : WRITE_DATA;
                        end
                    end
                end
                DUMMY: begin
                    if (w_sck_rise) begin
                        w_count = r_count + 3'd1;
                        if (r_count == c_dummy_last) begin
                            // RAM output has settled on the start address during the dummy phase.
                            w_count   = 3'd0;
                            w_state   = READ_DATA;
                            w_rd_byte = w_mem_rdata;
                            w_addr    = r_addr + c_addr_one;
                        end
                    end
                end
                WRITE_DATA: begin
                    if (w_sck_rise) begin
                        w_shift = w_data_byte;
                        if (r_count == 3'd0) begin
                            w_count = 3'd1;
                        end else begin
                            w_count  = 3'd0;
                            w_mem_we = 1'b1;
                            w_addr   = r_addr + c_addr_one;
                        end
                    end
                end
                READ_DATA: begin
                    if (w_sck_fall) begin
                        w_oe = 1'b1;
                        if (r_count == 3'd0) begin
                            w_sio_o = r_rd_byte[7:4];
                            w_count = 3'd1;
                        end else begin
                            // Address was already advanced, so the next byte is waiting.
                            w_sio_o   = r_rd_byte[3:0];
                            w_count   = 3'd0;
                            w_rd_byte = w_mem_rdata;
                            w_addr    = r_addr + c_addr_one;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sck_prev  <= 1'b0;
            r_cs_n_prev <= 1'b0;
            r_selected  <= 1'b0;
            r_count     <= 3'd0;
            r_shift     <= 8'd0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_rd_byte   <= 8'd0;
            r_sio_o     <= 4'd0;
            r_oe        <= 1'b0;
            r_quad      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sck_prev  <= sram_sck;
            r_cs_n_prev <= sram_cs_n;
            r_selected  <= ~sram_cs_n;
            r_count     <= w_count;
            r_shift     <= w_shift;
            r_addr      <= w_addr;
            r_is_read   <= w_is_read;
            r_cmd_done  <= w_cmd_done;
            r_rd_byte   <= w_rd_byte;
            r_sio_o     <= w_sio_o;
            r_oe        <= w_oe;
            r_quad      <= w_quad;
        end
    end

    qspi_sram_responder_mem #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (r_addr),
        .wdata (w_data_byte),
        .rdata (w_mem_rdata)
    );

    assign sram_sio_o  = r_sio_o;
    assign sram_sio_oe = r_oe;
    assign quad_mode   = r_quad;
    assign selected    = r_selected;

endmodule
`default_nettype wire

// File: tb/tb_qspi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_sram_responder
// Brief    : Directed scoreboard bench for the QSPI SRAM responder.
// Revision : 1.0
// ============================================================================
module tb_qspi_sram_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sram_cs_n = 1'b1;
    logic       sram_sck = 1'b0;
    logic [3:0] sram_sio_i = 4'd0;
    logic [3:0] sram_sio_o;
    logic       sram_sio_oe;
    logic       quad_mode;
    logic       selected;

    int         checks = 0;
    int         failures = 0;
    int         oe_viol = 0;
    logic       oe_allowed = 1'b0;
    logic [3:0] exp_q[$];
    logic       sck_d = 1'b0;
    logic       fall_seen = 1'b0;

    qspi_sram_responder #(
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sram_cs_n   (sram_cs_n),
        .sram_sck    (sram_sck),
        .sram_sio_i  (sram_sio_i),
        .sram_sio_o  (sram_sio_o),
        .sram_sio_oe (sram_sio_oe),
        .quad_mode   (quad_mode),
        .selected    (selected)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every SCK fall with the bus driven must match the next queued nibble.
    always @(posedge clk) begin
        sck_d     <= sram_sck;
        fall_seen <= sck_d & ~sram_sck;
    end

    always @(negedge clk) begin
        if (sram_sio_oe && !oe_allowed) oe_viol++;
        if (fall_seen && sram_sio_oe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_nibble", {28'd0, sram_sio_o}, 32'hDEAD);
            end else begin
                check("read_nibble", {28'd0, sram_sio_o}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] n);
        sram_sio_i = n;
        sram_sck   = 1'b1;
        wait_clk(2);
        sram_sck   = 1'b0;
        wait_clk(2);
    endtask

    task automatic cs_low();
        sram_cs_n = 1'b0;
        wait_clk(2);
    endtask

    task automatic cs_high();
        sram_cs_n = 1'b1;
        wait_clk(1);
        check("oe_after_cs_rise", {31'd0, sram_sio_oe}, 32'd0);
        oe_allowed = 1'b0;
        wait_clk(2);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
    endtask

    task automatic cmd_quad(input logic [7:0] c);
        cs_low();
        pulse(c[7:4]);
        pulse(c[3:0]);
    endtask

    task automatic addr24(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
    endtask

    task automatic write_n(input logic [23:0] a, input int n, input logic [15:0] bytes);
        logic [7:0] b;
        cmd_quad(8'h02);
        addr24(a);
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? bytes[15:8] : bytes[7:0];
            pulse(b[7:4]);
            pulse(b[3:0]);
        end
        cs_high();
    endtask

    task automatic read_n(input logic [23:0] a, input int n, input logic [15:0] bytes);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? bytes[15:8] : bytes[7:0];
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
        cmd_quad(8'h03);
        addr24(a);
        pulse(4'h0);
        oe_allowed = 1'b1;
        pulse(4'h0);
        for (int k = 0; k < 2*n - 1; k++) pulse(4'h0);
        cs_high();
        check("read_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        wait_clk(3);
        check("reset_oe",       {31'd0, sram_sio_oe}, 32'd0);
        check("reset_sio_o",    {28'd0, sram_sio_o},  32'd0);
        check("reset_quad",     {31'd0, quad_mode},   32'd0);
        check("reset_selected", {31'd0, selected},    32'd0);
        reset = 1'b0;
        wait_clk(2);

        // SPI-mode EQIO enters quad mode at CS rise.
        cs_low();
        check("selected_low_cs", {31'd0, selected}, 32'd1);
        spi_byte(8'h38);
        check("quad_before_cs_rise", {31'd0, quad_mode}, 32'd0);
        cs_high();
        check("quad_after_eqio", {31'd0, quad_mode}, 32'd1);
        check("selected_high_cs", {31'd0, selected}, 32'd0);

        // Basic write then read back.
        write_n(24'h001536, 2, 16'h650F);
        read_n(24'h001536, 2, 16'h650F);

        // Address wrap at the top of the array.
        write_n(24'h0003FF, 2, 16'hAA55);
        read_n(24'h0003FF, 2, 16'hAA55);
        read_n(24'h000000, 1, 16'h5500);

        // Partial trailing byte is dropped; following location keeps its value.
        write_n(24'h000200, 2, 16'h1277);
        cmd_quad(8'h02);
        addr24(24'h000200);
        pulse(4'h3); pulse(4'h4); pulse(4'h9);
        cs_high();
        read_n(24'h000200, 2, 16'h3477);

        // Unknown command is ignored: no write, no drive.
        cmd_quad(8'h9C);
        addr24(24'h001536);
        pulse(4'h1); pulse(4'h1);
        cs_high();
        check("quad_after_ignore", {31'd0, quad_mode}, 32'd1);
        read_n(24'h001536, 2, 16'h650F);

        // Reset in the middle of a read.
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hA);
        cmd_quad(8'h03);
        addr24(24'h0003FF);
        pulse(4'h0);
        oe_allowed = 1'b1;
        pulse(4'h0);
        pulse(4'h0);
        check("mid_read_drained", exp_q.size(), 32'd0);
        check("oe_mid_read", {31'd0, sram_sio_oe}, 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("oe_after_reset",   {31'd0, sram_sio_oe}, 32'd0);
        check("quad_after_reset", {31'd0, quad_mode},   32'd0);
        oe_allowed = 1'b0;
        reset = 1'b0;
        wait_clk(2);

        // CS still low from before reset: an EQIO here must be ignored.
        spi_byte(8'h38);
        cs_high();
        check("stale_cs_ignored", {31'd0, quad_mode}, 32'd0);

        cs_low();
        spi_byte(8'h38);
        cs_high();
        check("quad_reenabled", {31'd0, quad_mode}, 32'd1);
        read_n(24'h0003FF, 2, 16'hAA55);

        // RSTIO returns to SPI mode.
        cmd_quad(8'hFF);
        check("quad_before_rstio_rise", {31'd0, quad_mode}, 32'd1);
        cs_high();
        check("quad_after_rstio", {31'd0, quad_mode}, 32'd0);

        check("oe_outside_read", oe_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
